// File: rtl/fx_seq_pkg.sv
// Shared types and defaults for the effect frame sequencer.
package fx_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_SRC,
    S_ISSUE,
    S_WAIT_FX,
    S_DRAIN,
    S_CFG
  } state_t;

  // 32 samples x 16 bit per frame
  localparam int FRAME_BYTES_DEFAULT = 64;

  typedef logic [3:0]  magnitude_t;
  typedef logic [15:0] frame_count_t;

endpackage

// File: rtl/fx_watchdog.sv
// Cycle counter that flags an effect stall once TIMEOUT cycles pass without done.
module fx_watchdog
  import fx_seq_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_active,
  input  logic i_done,
  output logic o_expired
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_count;

  // Counts cycles spent waiting; the last waiting cycle is the one that expires.
  always_ff @(posedge i_clk) begin
    if (i_rst || !i_active || i_done) begin
      r_count <= '0;
    end else if (r_count != LIMIT) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = i_active && !i_done && (r_count == LIMIT);

endmodule

// File: rtl/effect_frame_sequencer.sv
// Steps 32-sample frames through one effect stage; config is applied only between frames.
// Optional stall watchdog enabled by defining WATCHDOG_EN.
module effect_frame_sequencer
  import fx_seq_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int FRAME_BYTES = FRAME_BYTES_DEFAULT,
  parameter int TIMEOUT     = 255
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [15:0]       i_num_frames,
  output logic              o_busy,
  output logic              o_run_done,
  input  logic              i_src_frame_valid,
  output logic              o_src_frame_ack,
  output logic              o_fx_prev_done,
  input  logic              i_fx_ready_for_data,
  input  logic              i_fx_done,
  output logic              o_fx_next_ready,
  output logic [ADDR_W-1:0] o_fx_address,
  input  logic              i_sink_ready,
  output logic              o_sink_write,
  input  logic              i_cfg_valid,
  input  logic [3:0]        i_cfg_magnitude,
  input  logic              i_cfg_en,
  output logic              o_cfg_ready,
  output logic [3:0]        o_fx_magnitude,
  output logic              o_fx_set_magnitude,
  output logic              o_fx_en,
  output logic              o_timeout_err
);

  state_t            r_state;
  state_t            r_cfg_ret;
  logic [ADDR_W-1:0] r_addr;
  frame_count_t      r_count;
  frame_count_t      r_num;
  logic              r_run_done;
  logic              r_src_ack;
  logic              r_prev_done;
  logic              r_next_ready;
  logic              r_sink_write;
  logic              r_set_mag;
  magnitude_t        r_mag;
  logic              r_en;
  logic              r_timeout_err;

  logic w_cfg_window;
  logic w_cfg_take;
  logic w_last;
  logic w_expired;

  // Settings may only change while no frame is inside the effect.
  assign w_cfg_window = (r_state == S_IDLE) ||
                        ((r_state == S_WAIT_SRC) && i_fx_ready_for_data);
  assign w_cfg_take   = i_cfg_valid && w_cfg_window;
  assign w_last       = (frame_count_t'(r_count + 16'd1) == r_num);

`ifdef WATCHDOG_EN
  fx_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_active  (r_state == S_WAIT_FX),
    .i_done    (i_fx_done),
    .o_expired (w_expired)
  );
`else
  localparam int unused_timeout = TIMEOUT;
  assign w_expired = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_cfg_ret     <= S_IDLE;
      r_addr        <= '0;
      r_count       <= '0;
      r_num         <= '0;
      r_run_done    <= 1'b0;
      r_src_ack     <= 1'b0;
      r_prev_done   <= 1'b0;
      r_next_ready  <= 1'b0;
      r_sink_write  <= 1'b0;
      r_set_mag     <= 1'b0;
      r_mag         <= '0;
      r_en          <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_run_done   <= 1'b0;
      r_src_ack    <= 1'b0;
      r_prev_done  <= 1'b0;
      r_next_ready <= 1'b0;
      r_sink_write <= 1'b0;
      r_set_mag    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_cfg_take) begin
            r_mag     <= i_cfg_magnitude;
            r_en      <= i_cfg_en;
            r_set_mag <= 1'b1;
            r_cfg_ret <= S_IDLE;
            r_state   <= S_CFG;
          end else if (i_start) begin
            r_timeout_err <= 1'b0;
            if (i_num_frames == 16'd0) begin
              r_run_done <= 1'b1;
            end else begin
              r_addr  <= i_base_addr;
              r_num   <= i_num_frames;
              r_count <= '0;
              r_state <= S_WAIT_SRC;
            end
          end
        end
        S_WAIT_SRC: begin
          if (w_cfg_take) begin
            r_mag     <= i_cfg_magnitude;
            r_en      <= i_cfg_en;
            r_set_mag <= 1'b1;
            r_cfg_ret <= S_WAIT_SRC;
            r_state   <= S_CFG;
          end else if (i_src_frame_valid && i_fx_ready_for_data) begin
            r_src_ack   <= 1'b1;
            r_prev_done <= 1'b1;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_state <= S_WAIT_FX;
        end
        S_WAIT_FX: begin
          if (i_fx_done) begin
            r_state <= S_DRAIN;
          end else if (w_expired) begin
            // Release the stalled effect and abandon the run.
            r_next_ready  <= 1'b1;
            r_timeout_err <= 1'b1;
            r_run_done    <= 1'b1;
            r_state       <= S_IDLE;
          end
        end
        S_DRAIN: begin
          if (i_sink_ready) begin
            r_next_ready <= 1'b1;
            r_sink_write <= 1'b1;
            r_addr       <= r_addr + ADDR_W'(FRAME_BYTES);
            r_count      <= frame_count_t'(r_count + 16'd1);
            if (w_last) begin
              r_run_done <= 1'b1;
              r_state    <= S_IDLE;
            end else begin
              r_state <= S_WAIT_SRC;
            end
          end
        end
        S_CFG: begin
          r_state <= r_cfg_ret;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy             = (r_state != S_IDLE);
  assign o_run_done         = r_run_done;
  assign o_src_frame_ack    = r_src_ack;
  assign o_fx_prev_done     = r_prev_done;
  assign o_fx_next_ready    = r_next_ready;
  assign o_fx_address       = r_addr;
  assign o_sink_write       = r_sink_write;
  assign o_cfg_ready        = w_cfg_take;
  assign o_fx_magnitude     = r_mag;
  assign o_fx_set_magnitude = r_set_mag;
  assign o_fx_en            = r_en;
  assign o_timeout_err      = r_timeout_err;

endmodule

// File: tb/tb_effect_frame_sequencer.sv
// Self-checking bench for effect_frame_sequencer: directed scenarios plus randomized runs
// compared against an event-level model of frame timing and addressing.
module tb_effect_frame_sequencer;

  localparam int TB_TIMEOUT = 8;
  localparam int MAXC       = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] num_frames;
  logic        busy, run_done;
  logic        src_frame_valid, src_frame_ack;
  logic        fx_prev_done, fx_ready_for_data, fx_done, fx_next_ready;
  logic [31:0] fx_address;
  logic        sink_ready, sink_write;
  logic        cfg_valid;
  logic [3:0]  cfg_magnitude;
  logic        cfg_en, cfg_ready;
  logic [3:0]  fx_magnitude;
  logic        fx_set_magnitude, fx_en, timeout_err;

  always #5 clk = ~clk;

  effect_frame_sequencer #(
    .ADDR_W      (32),
    .FRAME_BYTES (64),
    .TIMEOUT     (TB_TIMEOUT)
  ) dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_start             (start),
    .i_base_addr         (base_addr),
    .i_num_frames        (num_frames),
    .o_busy              (busy),
    .o_run_done          (run_done),
    .i_src_frame_valid   (src_frame_valid),
    .o_src_frame_ack     (src_frame_ack),
    .o_fx_prev_done      (fx_prev_done),
    .i_fx_ready_for_data (fx_ready_for_data),
    .i_fx_done           (fx_done),
    .o_fx_next_ready     (fx_next_ready),
    .o_fx_address        (fx_address),
    .i_sink_ready        (sink_ready),
    .o_sink_write        (sink_write),
    .i_cfg_valid         (cfg_valid),
    .i_cfg_magnitude     (cfg_magnitude),
    .i_cfg_en            (cfg_en),
    .o_cfg_ready         (cfg_ready),
    .o_fx_magnitude      (fx_magnitude),
    .o_fx_set_magnitude  (fx_set_magnitude),
    .o_fx_en             (fx_en),
    .o_timeout_err       (timeout_err)
  );

  int testsRun    = 0;
  int testsFailed = 0;

  // Per-run event log, indexed by cycle since start was driven.
  int          ackCyc[$];
  logic [31:0] ackAddr[$];
  int          wrCyc[$];
  int          doneCyc[$];
  int          nrCyc[$];
  int          fxDoneCyc[$];
  int          setMagCyc[$];
  logic [3:0]  setMagVal[$];
  logic        setMagEn[$];
  int          cfgRdyCyc[$];
  int          addrUnstable;
  int          prevMis;
  int          teHigh;
  int          busyCnt;
  bit          timedOut;

  bit srcV[MAXC];
  bit fxR[MAXC];
  bit sinkR[MAXC];

  task automatic fill_ones();
    for (int i = 0; i < MAXC; i++) begin
      srcV[i] = 1'b1; fxR[i] = 1'b1; sinkR[i] = 1'b1;
    end
  endtask

  // fxDelay=0 means the effect never reports done; sinkHold<0 uses the random sinkR pattern.
  task automatic drive_run(input logic [31:0] base, input int n, input int fxDelay,
                           input int sinkHold, input bit cfgReq, input int budget);
    int cd, drainCnt, doneAt;
    bit inFrame, seenDone, cfgArmed, rdyNow, dropNow;
    logic [31:0] curAddr;
    ackCyc.delete(); ackAddr.delete(); wrCyc.delete(); doneCyc.delete(); nrCyc.delete();
    fxDoneCyc.delete(); setMagCyc.delete(); setMagVal.delete(); setMagEn.delete(); cfgRdyCyc.delete();
    addrUnstable = 0; prevMis = 0; teHigh = 0; busyCnt = 0;
    cd = 0; drainCnt = 0; doneAt = 0; inFrame = 0; seenDone = 0; cfgArmed = 0; dropNow = 0;
    curAddr = '0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      rdyNow = 1'b0;
      if (sink_write) begin
        wrCyc.push_back(k);
        inFrame = 1'b0;
      end
      if (src_frame_ack) begin
        ackCyc.push_back(k); ackAddr.push_back(fx_address);
        inFrame = 1'b1; curAddr = fx_address;
        cd = (fxDelay > 0) ? fxDelay + 1 : 0;
      end else if (inFrame && fx_address !== curAddr) begin
        addrUnstable++;
      end
      if (fx_prev_done !== src_frame_ack) prevMis++;
      if (fx_next_ready) nrCyc.push_back(k);
      if (run_done) begin
        doneCyc.push_back(k);
        if (!seenDone) doneAt = k;
        seenDone = 1'b1;
      end
      if (fx_set_magnitude) begin
        setMagCyc.push_back(k); setMagVal.push_back(fx_magnitude); setMagEn.push_back(fx_en);
      end
      if (cfg_ready) begin
        cfgRdyCyc.push_back(k);
        rdyNow = 1'b1;
      end
      if (timeout_err) teHigh++;
      if (busy) busyCnt++;

      start           = (k == 0);
      base_addr       = base;
      num_frames      = n[15:0];
      src_frame_valid = srcV[k];
      fx_ready_for_data = fxR[k];
      if (sinkHold < 0) begin
        sink_ready = sinkR[k];
      end else if (drainCnt > 0) begin
        sink_ready = 1'b0;
        drainCnt--;
      end else begin
        sink_ready = 1'b1;
      end
      fx_done = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          fx_done = 1'b1;
          fxDoneCyc.push_back(k);
          drainCnt = (sinkHold > 0) ? sinkHold : 0;
        end
      end
      if (dropNow) cfg_valid = 1'b0;
      dropNow = rdyNow;
      if (cfgReq && !cfgArmed && ackCyc.size() == 1 && k > ackCyc[0]) begin
        cfg_valid = 1'b1; cfg_magnitude = 4'hA; cfg_en = 1'b1; cfgArmed = 1'b1;
      end
      if (seenDone && k >= doneAt + 3) break;
    end
    timedOut  = !seenDone;
    start     = 1'b0;
    cfg_valid = 1'b0;
    fx_done   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    testsRun++;
    if (busy !== 1'b0 || run_done !== 1'b0 || src_frame_ack !== 1'b0 || fx_prev_done !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_ctrl: busy/done/ack/prev=%b%b%b%b expected 0000", busy, run_done, src_frame_ack, fx_prev_done);
    end
    testsRun++;
    if (fx_next_ready !== 1'b0 || sink_write !== 1'b0 || fx_set_magnitude !== 1'b0 || timeout_err !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_pulses: nr/wr/setmag/te=%b%b%b%b expected 0000", fx_next_ready, sink_write, fx_set_magnitude, timeout_err);
    end
    testsRun++;
    if (fx_address !== 32'h0 || fx_magnitude !== 4'h0 || fx_en !== 1'b0 || cfg_ready !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_regs: addr=%h mag=%h en=%b cfg_ready=%b expected 0", fx_address, fx_magnitude, fx_en, cfg_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    testsRun++;
    if (busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_release_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_three_frames();
    int expAck[3] = '{2, 7, 12};
    int expWr[3]  = '{6, 11, 16};
    logic [31:0] expAddr[3] = '{32'h1000, 32'h1040, 32'h1080};
    fill_ones();
    drive_run(32'h1000, 3, 2, 0, 1'b0, 200);
    testsRun++;
    if (timedOut || ackCyc.size() != 3 || wrCyc.size() != 3) begin
      testsFailed++;
      $display("[TB] FAIL three_counts: acks=%0d writes=%0d timedOut=%0d expected 3 3 0", ackCyc.size(), wrCyc.size(), timedOut);
    end else begin
      for (int i = 0; i < 3; i++) begin
        testsRun++;
        if (ackCyc[i] != expAck[i] || wrCyc[i] != expWr[i] || ackAddr[i] !== expAddr[i]) begin
          testsFailed++;
          $display("[TB] FAIL three_frame%0d: ack@%0d wr@%0d addr=%h expected ack@%0d wr@%0d addr=%h",
                   i, ackCyc[i], wrCyc[i], ackAddr[i], expAck[i], expWr[i], expAddr[i]);
        end
      end
    end
    testsRun++;
    if (doneCyc.size() != 1 || doneCyc[0] != 16) begin
      testsFailed++;
      $display("[TB] FAIL three_run_done: pulses=%0d first@%0d expected 1 @16", doneCyc.size(), (doneCyc.size() > 0) ? doneCyc[0] : -1);
    end
    testsRun++;
    if (nrCyc != wrCyc || prevMis != 0 || addrUnstable != 0) begin
      testsFailed++;
      $display("[TB] FAIL three_handshake: next_ready=%0d writes=%0d prevMis=%0d addrUnstable=%0d expected equal,0,0",
               nrCyc.size(), wrCyc.size(), prevMis, addrUnstable);
    end
    testsRun++;
    if (busyCnt != 15 || teHigh != 0 || setMagCyc.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL three_busy: busyCycles=%0d te=%0d setmag=%0d expected 15 0 0", busyCnt, teHigh, setMagCyc.size());
    end
  endtask

  task automatic test_zero_frames();
    fill_ones();
    drive_run(32'h5000, 0, 1, 0, 1'b0, 50);
    testsRun++;
    if (timedOut || doneCyc.size() != 1 || doneCyc[0] != 1) begin
      testsFailed++;
      $display("[TB] FAIL zero_run_done: pulses=%0d timedOut=%0d expected one pulse at cycle 1", doneCyc.size(), timedOut);
    end
    testsRun++;
    if (ackCyc.size() != 0 || busyCnt != 0) begin
      testsFailed++;
      $display("[TB] FAIL zero_no_activity: acks=%0d busyCycles=%0d expected 0 0", ackCyc.size(), busyCnt);
    end
  endtask

  task automatic test_cfg_deferral();
    fill_ones();
    drive_run(32'h4000, 2, 3, 0, 1'b1, 200);
    testsRun++;
    if (timedOut || wrCyc.size() != 2 || ackCyc.size() != 2) begin
      testsFailed++;
      $display("[TB] FAIL cfg_run: acks=%0d writes=%0d timedOut=%0d expected 2 2 0", ackCyc.size(), wrCyc.size(), timedOut);
    end else begin
      testsRun++;
      if (cfgRdyCyc.size() != 1 || cfgRdyCyc[0] != wrCyc[0] || wrCyc[0] != 7) begin
        testsFailed++;
        $display("[TB] FAIL cfg_ready_window: readyCycles=%0d first@%0d expected 1 @7 (drain end %0d)",
                 cfgRdyCyc.size(), (cfgRdyCyc.size() > 0) ? cfgRdyCyc[0] : -1, wrCyc[0]);
      end
      testsRun++;
      if (setMagCyc.size() != 1 || setMagCyc[0] != 8 || ackCyc[1] != 10) begin
        testsFailed++;
        $display("[TB] FAIL cfg_strobe_timing: strobes=%0d first@%0d nextAck@%0d expected 1 @8 ack@10",
                 setMagCyc.size(), (setMagCyc.size() > 0) ? setMagCyc[0] : -1, ackCyc[1]);
      end else begin
        testsRun++;
        if (setMagVal[0] !== 4'hA || setMagEn[0] !== 1'b1) begin
          testsFailed++;
          $display("[TB] FAIL cfg_values: mag=%h en=%b expected a 1", setMagVal[0], setMagEn[0]);
        end
      end
    end
  endtask

  task automatic test_sink_backpressure();
    fill_ones();
    drive_run(32'h3000, 1, 1, 10, 1'b0, 200);
    testsRun++;
    if (timedOut || fxDoneCyc.size() != 1 || wrCyc.size() != 1) begin
      testsFailed++;
      $display("[TB] FAIL hold_counts: fxDone=%0d writes=%0d timedOut=%0d expected 1 1 0", fxDoneCyc.size(), wrCyc.size(), timedOut);
    end else begin
      testsRun++;
      if (wrCyc[0] != fxDoneCyc[0] + 12) begin
        testsFailed++;
        $display("[TB] FAIL hold_write_time: write@%0d expected @%0d", wrCyc[0], fxDoneCyc[0] + 12);
      end
      testsRun++;
      if (nrCyc.size() != 1 || nrCyc[0] != wrCyc[0] || doneCyc.size() != 1 || doneCyc[0] != wrCyc[0]) begin
        testsFailed++;
        $display("[TB] FAIL hold_next_ready: nrPulses=%0d donePulses=%0d expected 1 1 at @%0d", nrCyc.size(), doneCyc.size(), wrCyc[0]);
      end
    end
  endtask

  task automatic test_addr_wrap();
    fill_ones();
    drive_run(32'hFFFF_FFC0, 2, 1, 0, 1'b0, 200);
    testsRun++;
    if (timedOut || ackAddr.size() != 2) begin
      testsFailed++;
      $display("[TB] FAIL wrap_count: acks=%0d timedOut=%0d expected 2 0", ackAddr.size(), timedOut);
    end else begin
      testsRun++;
      if (ackAddr[0] !== 32'hFFFF_FFC0 || ackAddr[1] !== 32'h0000_0000) begin
        testsFailed++;
        $display("[TB] FAIL wrap_addr: got %h %h expected ffffffc0 00000000", ackAddr[0], ackAddr[1]);
      end
      testsRun++;
      if (ackCyc[1] - ackCyc[0] != 4) begin
        testsFailed++;
        $display("[TB] FAIL min_latency: frame spacing %0d expected 4", ackCyc[1] - ackCyc[0]);
      end
    end
  endtask

  task automatic test_random_runs();
    for (int r = 0; r < 5; r++) begin
      int n, dly, t, u, eAck, eWr;
      logic [31:0] base;
      n    = $urandom_range(1, 5);
      dly  = $urandom_range(1, 4);
      base = $urandom;
      for (int i = 0; i < MAXC; i++) begin
        srcV[i]  = ($urandom_range(0, 3) != 0);
        fxR[i]   = ($urandom_range(0, 3) != 0);
        sinkR[i] = ($urandom_range(0, 1) != 0);
      end
      drive_run(base, n, dly, -1, 1'b0, 1000);
      testsRun++;
      if (timedOut || ackCyc.size() != n || wrCyc.size() != n || doneCyc.size() != 1) begin
        testsFailed++;
        $display("[TB] FAIL rand%0d_counts: acks=%0d writes=%0d done=%0d expected %0d %0d 1",
                 r, ackCyc.size(), wrCyc.size(), doneCyc.size(), n, n);
        continue;
      end
      // Event model: issue one cycle after the first ready source cycle, drain one cycle after the first ready sink cycle.
      t = 1;
      eWr = 0;
      for (int i = 0; i < n; i++) begin
        while (t < MAXC - 2 && !(srcV[t] && fxR[t])) t++;
        eAck = t + 1;
        u = eAck + dly + 1;
        while (u < MAXC - 2 && !sinkR[u]) u++;
        eWr = u + 1;
        testsRun++;
        if (ackCyc[i] != eAck || wrCyc[i] != eWr || ackAddr[i] !== base + 32'(i * 64)) begin
          testsFailed++;
          $display("[TB] FAIL rand%0d_frame%0d: ack@%0d wr@%0d addr=%h expected ack@%0d wr@%0d addr=%h",
                   r, i, ackCyc[i], wrCyc[i], ackAddr[i], eAck, eWr, base + 32'(i * 64));
        end
        t = eWr;
      end
      testsRun++;
      if (doneCyc[0] != eWr || nrCyc != wrCyc || addrUnstable != 0 || prevMis != 0) begin
        testsFailed++;
        $display("[TB] FAIL rand%0d_end: done@%0d expected @%0d nrMatch=%0d addrUnstable=%0d prevMis=%0d",
                 r, doneCyc[0], eWr, (nrCyc == wrCyc), addrUnstable, prevMis);
      end
    end
  endtask

  task automatic test_reset_midrun();
    int bad;
    fill_ones();
    @(negedge clk);
    start = 1'b1; base_addr = 32'h2000; num_frames = 16'd4;
    src_frame_valid = 1'b1; fx_ready_for_data = 1'b1; sink_ready = 1'b1; fx_done = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    testsRun++;
    if (busy !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL midrun_busy: got %b expected 1", busy);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (run_done !== 1'b0 || busy !== 1'b0 || fx_address !== 32'h0) bad++;
      @(negedge clk);
    end
    testsRun++;
    if (bad != 0) begin
      testsFailed++;
      $display("[TB] FAIL midrun_abandon: %0d cycles with activity after reset, expected 0", bad);
    end
  endtask

`ifdef WATCHDOG_EN
  task automatic test_watchdog();
    fill_ones();
    drive_run(32'h6000, 3, 0, 0, 1'b0, 100);
    testsRun++;
    if (timedOut || ackCyc.size() != 1 || doneCyc.size() != 1) begin
      testsFailed++;
      $display("[TB] FAIL wd_run: acks=%0d done=%0d timedOut=%0d expected 1 1 0", ackCyc.size(), doneCyc.size(), timedOut);
    end else begin
      testsRun++;
      if (doneCyc[0] != ackCyc[0] + 1 + TB_TIMEOUT || nrCyc.size() != 1 || nrCyc[0] != doneCyc[0] || wrCyc.size() != 0) begin
        testsFailed++;
        $display("[TB] FAIL wd_timing: done@%0d expected @%0d nrPulses=%0d writes=%0d",
                 doneCyc[0], ackCyc[0] + 1 + TB_TIMEOUT, nrCyc.size(), wrCyc.size());
      end
      testsRun++;
      if (teHigh != 4) begin
        testsFailed++;
        $display("[TB] FAIL wd_sticky: timeout_err high %0d cycles expected 4", teHigh);
      end
    end
    drive_run(32'h0, 0, 1, 0, 1'b0, 50);
    testsRun++;
    if (teHigh != 1 || timeout_err !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL wd_clear: high %0d cycles now=%b expected 1 then 0", teHigh, timeout_err);
    end
  endtask
`endif

  initial begin
    #500000;
    $display("[TB] FAIL global_time_limit: simulation did not finish");
    $fatal(1, "[TB] time limit reached");
  end

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; num_frames = '0;
    src_frame_valid = 1'b0; fx_ready_for_data = 1'b0; fx_done = 1'b0; sink_ready = 1'b0;
    cfg_valid = 1'b0; cfg_magnitude = '0; cfg_en = 1'b0;
    test_reset();
    test_three_frames();
    test_zero_frames();
    test_cfg_deferral();
    test_sink_backpressure();
    test_addr_wrap();
    test_random_runs();
    test_reset_midrun();
`ifdef WATCHDOG_EN
    test_watchdog();
`endif
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
